// File: rtl/arith_pkg.sv
// Types and constants shared by the sequential arithmetic blocks (Booth multiplier, non-restoring divider).
package arith_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

  // Counter wide enough to hold 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A, then an arithmetic
// right shift of {A,Q,q_1}.
module booth_step
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_nxt,
  output logic [WIDTH-1:0] q_nxt,
  output logic             q_1_nxt,
  output logic             do_add,
  output logic             do_sub
);

  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;

  // A is one bit wider than M so that subtracting the most negative M cannot overflow.
  assign m_ext = {m[WIDTH-1], m};

  always_comb begin
    sum    = a;
    do_add = 1'b0;
    do_sub = 1'b0;
    case ({q[0], q_1})
      2'b10: begin
        sum    = a - m_ext;
        do_sub = 1'b1;
      end
      2'b01: begin
        sum    = a + m_ext;
        do_add = 1'b1;
      end
      default: ;
    endcase
  end

  assign a_nxt   = {sum[WIDTH], sum[WIDTH:1]};
  assign q_nxt   = {sum[0], q[WIDTH-1:1]};
  assign q_1_nxt = q[0];

endmodule

// File: rtl/booth_mul.sv
// Sequential signed radix-2 Booth multiplier: one multiplier bit per clock, full
// double-width product, and counts of the add/subtract operations performed.
module booth_mul
  import arith_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CW    = cnt_width(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done,
  output logic [CW-1:0]      num_add,
  output logic [CW-1:0]      num_sub
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH:0]   a_reg, a_nxt;
  logic [WIDTH-1:0] q_reg, q_nxt;
  logic             q_1_reg, q_1_nxt;
  logic [CW-1:0]    count;
  logic             do_add, do_sub;
  logic             last;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a       (a_reg),
    .q       (q_reg),
    .q_1     (q_1_reg),
    .m       (m_reg),
    .a_nxt   (a_nxt),
    .q_nxt   (q_nxt),
    .q_1_nxt (q_1_nxt),
    .do_add  (do_add),
    .do_sub  (do_sub)
  );

  assign last = (count == CW'(WIDTH - 1));
  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Start is only looked at in IDLE, so a request during RUN leaves the latches alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reg   <= '0;
      a_reg   <= '0;
      q_reg   <= '0;
      q_1_reg <= 1'b0;
      count   <= '0;
      num_add <= '0;
      num_sub <= '0;
      product <= '0;
      done    <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        m_reg   <= multiplicand;
        a_reg   <= '0;
        q_reg   <= multiplier;
        q_1_reg <= 1'b0;
        count   <= '0;
        num_add <= '0;
        num_sub <= '0;
        done    <= 1'b0;
      end
    end else begin
      a_reg   <= a_nxt;
      q_reg   <= q_nxt;
      q_1_reg <= q_1_nxt;
      count   <= count + CW'(1);
      if (do_add) num_add <= num_add + CW'(1);
      if (do_sub) num_sub <= num_sub + CW'(1);
      if (last) begin
        product <= {a_nxt[WIDTH-1:0], q_nxt};
        done    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_booth_mul.sv
// Directed and randomized checks of booth_mul at WIDTH=8 and WIDTH=32.
module tb_booth_mul;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic        start8 = 1'b0;
  logic [7:0]  mcand8 = '0, mplier8 = '0;
  logic [15:0] product8;
  logic        busy8, done8;
  logic [3:0]  num_add8, num_sub8;

  booth_mul #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .multiplicand(mcand8), .multiplier(mplier8),
    .product(product8), .busy(busy8), .done(done8),
    .num_add(num_add8), .num_sub(num_sub8)
  );

  // WIDTH=32 instance
  logic        start32 = 1'b0;
  logic [31:0] mcand32 = '0, mplier32 = '0;
  logic [63:0] product32;
  logic        busy32, done32;
  logic [5:0]  num_add32, num_sub32;

  booth_mul #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32),
    .multiplicand(mcand32), .multiplier(mplier32),
    .product(product32), .busy(busy32), .done(done32),
    .num_add(num_add32), .num_sub(num_sub32)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] prod;
    int          n_add;
    int          n_sub;
  } vec_t;

  vec_t vecs[10];

  task automatic wait_done8(inout int lat);
    while (!done8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic start_op8(input logic [7:0] m, input logic [7:0] q);
    @(negedge clk);
    mcand8 = m; mplier8 = q; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    mcand8 = ~m; mplier8 = ~q;
  endtask

  task automatic run32(input logic [31:0] m, input logic [31:0] q);
    longint pm, pq, exp_prod;
    int exp_add, exp_sub, lat;
    logic prev;
    pm = $signed(m);
    pq = $signed(q);
    exp_prod = pm * pq;
    exp_add = 0; exp_sub = 0; prev = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (q[i] && !prev) exp_sub++;
      if (!q[i] && prev) exp_add++;
      prev = q[i];
    end
    @(negedge clk);
    mcand32 = m; mplier32 = q; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    mcand32 = $urandom(); mplier32 = $urandom();
    lat = 0;
    while (!done32 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w32 latency", 64'(lat), 64'd32);
    chk("w32 product", product32, exp_prod);
    chk("w32 num_add", 64'(num_add32), 64'(exp_add));
    chk("w32 num_sub", 64'(num_sub32), 64'(exp_sub));
  endtask

  initial begin
    int lat;

    vecs[0] = '{8'd3,    8'd5,    16'h000F, 2, 2};
    vecs[1] = '{8'hF9,   8'd3,    16'hFFEB, 1, 1};
    vecs[2] = '{8'h80,   8'h80,   16'h4000, 0, 1};
    vecs[3] = '{8'd7,    8'hFF,   16'hFFF9, 0, 1};
    vecs[4] = '{8'd0,    8'h5A,   16'h0000, 3, 3};
    vecs[5] = '{8'h5A,   8'd0,    16'h0000, 0, 0};
    vecs[6] = '{8'd127,  8'd127,  16'h3F01, 1, 1};
    vecs[7] = '{8'h80,   8'd127,  16'hC080, 1, 1};
    vecs[8] = '{8'd127,  8'h80,   16'hC080, 0, 1};
    vecs[9] = '{8'hFF,   8'hFF,   16'h0001, 0, 1};

    // Reset state
    #12;
    chk("reset product8", 64'(product8), 64'd0);
    chk("reset busy8",    64'(busy8),    64'd0);
    chk("reset done8",    64'(done8),    64'd0);
    chk("reset num_add8", 64'(num_add8), 64'd0);
    chk("reset num_sub8", 64'(num_sub8), 64'd0);
    chk("reset product32", product32,    64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      start_op8(vecs[i].m, vecs[i].q);
      chk("accept busy8", 64'(busy8), 64'd1);
      chk("accept done8", 64'(done8), 64'd0);
      lat = 0;
      wait_done8(lat);
      chk("vec latency", 64'(lat), 64'd8);
      chk("vec product", 64'(product8), 64'(vecs[i].prod));
      chk("vec num_add", 64'(num_add8), 64'(vecs[i].n_add));
      chk("vec num_sub", 64'(num_sub8), 64'(vecs[i].n_sub));
      chk("vec busy8",   64'(busy8),    64'd0);
    end

    // done and product hold while idle
    repeat (3) @(posedge clk);
    #1;
    chk("hold done8",    64'(done8),    64'd1);
    chk("hold product8", 64'(product8), 64'hFFFF & 64'h0001);

    // Asynchronous reset mid-operation
    start_op8(8'd3, 8'd5);
    repeat (3) @(posedge clk);
    #2;
    chk("midrun num_sub8", 64'(num_sub8), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("async product8", 64'(product8), 64'd0);
    chk("async busy8",    64'(busy8),    64'd0);
    chk("async done8",    64'(done8),    64'd0);
    chk("async num_add8", 64'(num_add8), 64'd0);
    chk("async num_sub8", 64'(num_sub8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    start_op8(8'd3, 8'd5);
    lat = 0;
    wait_done8(lat);
    chk("post-reset latency", 64'(lat), 64'd8);
    chk("post-reset product", 64'(product8), 64'h000F);

    // Start during RUN is ignored
    start_op8(8'd3, 8'd5);
    lat = 0;
    repeat (2) begin @(posedge clk); lat++; end
    @(negedge clk);
    mcand8 = 8'd7; mplier8 = 8'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    lat++;
    start8 = 1'b0;
    wait_done8(lat);
    chk("ignored latency", 64'(lat), 64'd8);
    chk("ignored product", 64'(product8), 64'h000F);
    chk("ignored num_add", 64'(num_add8), 64'd2);
    @(posedge clk); #1;
    chk("ignored stays idle", 64'(busy8), 64'd0);

    // start held high: done lasts exactly one cycle, then the next op is accepted
    @(negedge clk);
    mcand8 = 8'd3; mplier8 = 8'd5; start8 = 1'b1;
    @(posedge clk); #1;
    mcand8 = 8'd7; mplier8 = 8'hFF;
    lat = 0;
    wait_done8(lat);
    chk("held latency", 64'(lat), 64'd8);
    chk("held product", 64'(product8), 64'h000F);
    @(posedge clk); #1;
    chk("held done pulse", 64'(done8), 64'd0);
    chk("held re-accept",  64'(busy8), 64'd1);
    start8 = 1'b0;
    lat = 0;
    wait_done8(lat);
    chk("held 2nd latency", 64'(lat), 64'd8);
    chk("held 2nd product", 64'(product8), 64'hFFF9);

    // WIDTH=32: corners then random pairs
    run32(32'h8000_0000, 32'h8000_0000);
    run32(32'h7FFF_FFFF, 32'h8000_0000);
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run32(32'h0000_0000, 32'hAAAA_AAAA);
    for (int i = 0; i < 1000; i++)
      run32($urandom(), $urandom());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
